id_ex_stage: RTL

ID/EX pipeline register and execute-stage operand selector for the five-stage pipeline. It captures the decoded instruction each cycle and drives the ALU's `arg1`, `arg2`, `ALU_op` and `shamt` inputs, applying register-file bypassing from the MEM and WB stages. It detects load-use and RAW hazards, stalls decode, and inserts bubbles. It sits between the decode stage and the ALU, and feeds the EX/MEM register.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: ALU opcodes, EX control bundle, width defaults
package pipe_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RW_DEFAULT = 5;

  typedef enum logic [4:0] {
    ALU_ADD = 5'b00000,
    ALU_SUB = 5'b00001,
    ALU_AND = 5'b00010,
    ALU_OR  = 5'b00011,
    ALU_NOR = 5'b00100,
    ALU_SLL = 5'b00101,
    ALU_SRL = 5'b00110,
    ALU_SRA = 5'b00111,
    ALU_SLT = 5'b01000
  } alu_op_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic use_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - register-file bypass selector, MEM result before WB data; r0 never bypassed
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          en_i,
  input  logic [RW-1:0] idx_i,
  input  logic [DW-1:0] rf_val_i,
  input  logic          mem_valid_i,
  input  logic          mem_reg_write_i,
  input  logic [RW-1:0] mem_dest_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_valid_i,
  input  logic          wb_reg_write_i,
  input  logic [RW-1:0] wb_dest_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] val_o
);

  logic mem_hit, wb_hit;

  always_comb begin
    mem_hit = en_i && mem_valid_i && mem_reg_write_i && (mem_dest_i != '0) && (mem_dest_i == idx_i);
    wb_hit  = en_i && wb_valid_i && wb_reg_write_i && (wb_dest_i != '0) && (wb_dest_i == idx_i);
    if (mem_hit)     val_o = mem_result_i;
    else if (wb_hit) val_o = wb_data_i;
    else             val_o = rf_val_i;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register, operand bypass and hazard stall.
// ID_EX_FORWARDING_EN enables MEM/WB bypass; without it RAW hazards stall until the producer reaches WB.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dest,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [4:0]    id_alu_op,
  input  logic [4:0]    id_shamt,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_valid,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_data,
  output logic          stall_id,
  output logic [DW-1:0] alu_arg1,
  output logic [DW-1:0] alu_arg2,
  output logic [4:0]    alu_op,
  output logic [4:0]    alu_shamt,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [RW-1:0] ex_dest,
  output logic [DW-1:0] ex_store_data
);

`ifdef ID_EX_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  ctrl_t         ctrl_q, ctrl_d;
  logic [RW-1:0] rs_q, rt_q, dest_q, rs_d, rt_d, dest_d;
  logic [DW-1:0] rs_val_q, rt_val_q, imm_q, rs_val_d, rt_val_d, imm_d;
  logic [4:0]    op_q, shamt_q, op_d, shamt_d;
  logic [DW-1:0] rs_fwd, rt_fwd;
  logic          rt_src, ex_w, mem_w, stall_raw;

  function automatic logic reg_hit(input logic [RW-1:0] dest, input logic [RW-1:0] src);
    return (dest != '0) && (dest == src);
  endfunction

  // rt is only a true source when it feeds the ALU or is store data
  assign rt_src = !id_use_imm || id_mem_write;
  assign ex_w   = ctrl_q.valid && ctrl_q.reg_write;
  assign mem_w  = mem_valid && mem_reg_write;

  always_comb begin
    stall_raw = 1'b0;
`ifdef ID_EX_FORWARDING_EN
    stall_raw = id_valid && ctrl_q.valid && ctrl_q.mem_read &&
                (reg_hit(dest_q, id_rs) || (rt_src && reg_hit(dest_q, id_rt)));
`else
    stall_raw = id_valid &&
                ((ex_w && (reg_hit(dest_q, id_rs) || (rt_src && reg_hit(dest_q, id_rt)))) ||
                 (mem_w && (reg_hit(mem_dest, id_rs) || (rt_src && reg_hit(mem_dest, id_rt)))));
`endif
  end

  assign stall_id = rst_n && !flush && stall_raw;

  always_comb begin
    ctrl_d   = CTRL_BUBBLE;
    rs_d     = '0;
    rt_d     = '0;
    dest_d   = '0;
    rs_val_d = '0;
    rt_val_d = '0;
    imm_d    = '0;
    op_d     = ALU_ADD;
    shamt_d  = '0;
    if (!flush && !stall_id) begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_valid && id_reg_write;
      ctrl_d.mem_read  = id_valid && id_mem_read;
      ctrl_d.mem_write = id_valid && id_mem_write;
      ctrl_d.use_imm   = id_use_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      dest_d   = id_dest;
      rs_val_d = id_rs_val;
      rt_val_d = id_rt_val;
      imm_d    = id_imm;
      op_d     = id_alu_op;
      shamt_d  = id_shamt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      rs_q     <= '0;
      rt_q     <= '0;
      dest_q   <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      op_q     <= ALU_ADD;
      shamt_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      dest_q   <= dest_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      imm_q    <= imm_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .en_i(FWD_EN), .idx_i(rs_q), .rf_val_i(rs_val_q),
    .mem_valid_i(mem_valid), .mem_reg_write_i(mem_reg_write), .mem_dest_i(mem_dest), .mem_result_i(mem_result),
    .wb_valid_i(wb_valid), .wb_reg_write_i(wb_reg_write), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .val_o(rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .en_i(FWD_EN), .idx_i(rt_q), .rf_val_i(rt_val_q),
    .mem_valid_i(mem_valid), .mem_reg_write_i(mem_reg_write), .mem_dest_i(mem_dest), .mem_result_i(mem_result),
    .wb_valid_i(wb_valid), .wb_reg_write_i(wb_reg_write), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
    .val_o(rt_fwd)
  );

  assign alu_arg1      = rs_fwd;
  assign alu_arg2      = ctrl_q.use_imm ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_op        = op_q;
  assign alu_shamt     = shamt_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_dest       = dest_q;

endmodule
